ic_axi_rd_resp: RTL

- Memory-side responder for the tiny AXI read bus driven by the I-cache miss controller.
- Captures a single-cycle line-read request and its byte address, then issues one 4-beat INCR AXI4 read burst of 32-bit beats.
- Assembles the returned beats into a 128-bit cache line and hands it back with a one-cycle valid strobe plus a finish strobe.
- Sits between the instruction cache and the system AXI interconnect.

---
 rtl/ic_axi_rd_resp.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ic_axi_rd_resp.sv
// I-cache line fetch responder: turns a one-cycle line request into a single
// 4-beat INCR AXI4 read and returns the assembled 128-bit line with strobes.
module ic_axi_rd_resp #(
  parameter int              IDW    = 4,
  parameter logic [IDW-1:0]  AXI_ID = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rst_pipe,
  input  logic           rd_start_rq,
  input  logic [31:0]    rd_in_addr,
  output logic [127:0]   rdat_m_data,
  output logic           rdat_m_valid,
  output logic           finish_mrd,
  output logic           rd_err,
  output logic           rd_busy,
  output logic [IDW-1:0] arid,
  output logic [31:0]    araddr,
  output logic [7:0]     arlen,
  output logic [2:0]     arsize,
  output logic [1:0]     arburst,
  output logic           arvalid,
  input  logic           arready,
  input  logic [IDW-1:0] rid,
  input  logic [31:0]    rdata,
  input  logic [1:0]     rresp,
  input  logic           rlast,
  input  logic           rvalid,
  output logic           rready
);

  typedef enum logic [1:0] {IDLE, ARREQ, RDAT, DONE} state_t;

  state_t      state;
  logic [31:0] addr;
  logic [1:0]  cnt;
  logic        err;
  logic        drop;
  logic        valid_q;
  logic        err_q;

  // Byte offset within the line is irrelevant; the burst always starts line-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^rd_in_addr[3:0];

  logic beat_ok;
  logic drop_now;
  logic beat_err;
  assign beat_ok  = rvalid & rready & (rid == AXI_ID);
  assign drop_now = drop | rst_pipe;
  assign beat_err = (rresp != 2'b00);

  assign arid    = AXI_ID;
  assign araddr  = {addr[31:4], 4'h0};
  assign arlen   = 8'd3;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // A pipeline reset arriving in the completion cycle must still kill the strobe.
  assign rdat_m_valid = valid_q & ~rst_pipe;
  assign rd_err       = err_q & ~rst_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      drop        <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      finish_mrd  <= 1'b0;
      rd_busy     <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      rdat_m_data <= '0;
    end else begin
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      finish_mrd <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_start_rq) begin
            addr        <= rd_in_addr;
            cnt         <= '0;
            err         <= 1'b0;
            rdat_m_data <= '0;
            arvalid     <= 1'b1;
            rd_busy     <= 1'b1;
            state       <= ARREQ;
          end
        end
        ARREQ: begin
          if (rst_pipe) drop <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RDAT;
          end
        end
        RDAT: begin
          if (rst_pipe) drop <= 1'b1;
          if (beat_ok) begin
            // Word index saturates so any overlong burst keeps landing in word 3.
            rdat_m_data[{cnt, 5'b0} +: 32] <= rdata;
            if (cnt != 2'd3) cnt <= cnt + 2'd1;
            if (beat_err) err <= 1'b1;
            if (rlast) begin
              rready     <= 1'b0;
              finish_mrd <= 1'b1;
              valid_q    <= ~drop_now;
              err_q      <= ~drop_now & (err | beat_err);
              state      <= DONE;
            end
          end
        end
        DONE: begin
          rd_busy <= 1'b0;
          drop    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
